// File: rtl/cacheline_adaptor_if.sv
// cacheline_adaptor_if
//   Bundles the cache-side line port and the memory-side burst port of the
//   cacheline adaptor.
//   Cache side : line_i, address_i, read_i, write_i -> ; <- line_o, resp_o
//   Memory side: burst_i, resp_i -> ; <- burst_o, address_o, read_o, write_o
//   Optional   : err_o (only when CACHELINE_ADAPTOR_ERR_EN is defined)
//   Modports   : slave  = the adaptor's view
//                master = the view of whatever drives the adaptor
interface cacheline_adaptor_if #(
  parameter int BURST_W   = 64,
  parameter int BURST_LEN = 4
);
  localparam int LINE_W = BURST_W * BURST_LEN;

  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic [31:0]        address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [BURST_W-1:0] burst_i;
  logic [BURST_W-1:0] burst_o;
  logic [31:0]        address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;
`ifdef CACHELINE_ADAPTOR_ERR_EN
  logic               err_o;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o, err_o
  );
  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o, err_o
  );
`else
  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );
  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
`endif
endinterface

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor
//   Converts one 256-bit cache-line read/write into a four-beat 64-bit
//   memory burst, then pulses resp_o for one cycle back to the cache.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset, aborts any burst in flight
//     bus   : cacheline_adaptor_if.slave (cache line port + memory burst port)
//   Optional feature macro: CACHELINE_ADAPTOR_ERR_EN adds the sticky err_o
//   protocol-error flag (stray resp_i in IDLE/DONE, or read_i and write_i
//   sampled together). Without it the flag and its logic do not exist.
module cacheline_adaptor #(
  parameter int BURST_W   = 64,
  parameter int BURST_LEN = 4
) (
  input logic          clk,
  input logic          rst_n,
  cacheline_adaptor_if.slave bus
);

  localparam int LINE_W = BURST_W * BURST_LEN;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RD_BURST = 2'd1;
  localparam logic [1:0] WR_BURST = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  // Line address mask: clears the byte offset within a 32-byte line.
  localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

  logic [1:0]        state;
  logic [1:0]        cnt;
  logic [LINE_W-1:0] wbuf;
  logic [LINE_W-1:0] line_q;
  logic [31:0]       addr_q;
  logic              read_q;
  logic              write_q;
  logic              resp_q;

  // NOTE: all state below uses non-blocking assignments so every register
  // updates from the same pre-edge values; blocking here would make the
  // result depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      // NOTE: the write buffer is reset too, because burst_o is read straight
      // out of it and must be zero after reset.
      wbuf    <= '0;
      line_q  <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 2'd0;
          // Read has priority; a simultaneous write stays pending in the
          // cache and is sampled again once this read completes.
          if (bus.read_i) begin
            addr_q <= bus.address_i & LINE_MASK;
            read_q <= 1'b1;
            state  <= RD_BURST;
          end else if (bus.write_i) begin
            addr_q  <= bus.address_i & LINE_MASK;
            wbuf    <= bus.line_i;
            write_q <= 1'b1;
            state   <= WR_BURST;
          end
        end

        RD_BURST: begin
          if (bus.resp_i) begin
            line_q[BURST_W*cnt +: BURST_W] <= bus.burst_i;
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              read_q <= 1'b0;
              resp_q <= 1'b1;
              state  <= DONE;
            end
          end
        end

        WR_BURST: begin
          if (bus.resp_i) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              write_q <= 1'b0;
              resp_q  <= 1'b1;
              state   <= DONE;
            end
          end
        end

        default: begin  // DONE
          resp_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // The current write beat comes straight out of the buffer, so it follows
  // the beat counter and holds while memory stalls.
  assign bus.burst_o   = wbuf[BURST_W*cnt +: BURST_W];
  assign bus.line_o    = line_q;
  assign bus.address_o = addr_q;
  assign bus.read_o    = read_q;
  assign bus.write_o   = write_q;
  assign bus.resp_o    = resp_q;

`ifdef CACHELINE_ADAPTOR_ERR_EN
  logic err_q;

  // Sticky until reset; observes the protocol only, never steers data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((bus.resp_i && (state == IDLE || state == DONE)) ||
                 (state == IDLE && bus.read_i && bus.write_i)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err_o = err_q;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor
//   Scoreboard bench for cacheline_adaptor. A cache-side driver pushes the
//   expected response of each line request into a queue; a monitor pops and
//   compares whenever resp_o pulses. A behavioural memory serves bursts from
//   a line-addressed array; a separate reference array holds what the cache
//   believes memory contains. Directed cases cover exact cycle timing.
module tb_cacheline_adaptor;

  typedef struct {
    bit           is_read;
    logic [31:0]  addr;
    logic [255:0] line;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cacheline_adaptor_if bus ();

  cacheline_adaptor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  exp_t         sb[$];
  logic [255:0] ref_mem[logic [31:0]];
  logic [255:0] phys_mem[logic [31:0]];
  bit           auto_mem  = 1'b0;
  bit           zero_wait = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom();
    return l;
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:5], 5'b0};
  endfunction

  function automatic logic [255:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  // Monitor: every resp_o pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.resp_o === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: got resp_o=1 expected no outstanding request");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_addr", bus.address_o, e.addr);
        if (e.is_read) check("resp_line", bus.line_o, e.line);
      end
    end
  end

  // Behavioural memory: serves one burst whenever read_o/write_o is up.
  initial begin : mem_model
    logic [31:0]  a;
    logic [255:0] line;
    bit           wr;
    bus.resp_i  = 1'b0;
    bus.burst_i = '0;
    forever begin
      @(negedge clk);
      if (auto_mem && rst_n === 1'b1 && (bus.read_o === 1'b1 || bus.write_o === 1'b1)) begin
        a    = bus.address_o;
        wr   = bus.write_o;
        line = phys_mem.exists(a) ? phys_mem[a] : '0;
        for (int b = 0; b < 4; b++) begin
          if (!zero_wait) begin
            while ($urandom_range(0, 2) == 0) begin
              bus.resp_i = 1'b0;
              @(negedge clk);
            end
          end
          bus.resp_i = 1'b1;
          if (wr) line[64*b +: 64] = bus.burst_o;
          else    bus.burst_i = line[64*b +: 64];
          @(negedge clk);
        end
        bus.resp_i = 1'b0;
        if (wr) phys_mem[a] = line;
      end
    end
  end

  task automatic wait_resp(input string name);
    int n = 0;
    while (bus.resp_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.resp_o !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got no resp_o within 100 cycles expected resp_o=1", name);
    end
  endtask

  // One complete cache transaction; returns at the negedge of the IDLE cycle.
  task automatic do_txn(input bit is_read, input logic [31:0] addr, input logic [255:0] line);
    exp_t e;
    e.is_read = is_read;
    e.addr    = align(addr);
    e.line    = is_read ? ref_rd(align(addr)) : line;
    sb.push_back(e);
    if (!is_read) ref_mem[align(addr)] = line;
    bus.address_i = addr;
    bus.line_i    = line;
    bus.read_i    = is_read;
    bus.write_i   = !is_read;
    @(negedge clk);
    bus.read_i  = 1'b0;
    bus.write_i = 1'b0;
    wait_resp("txn");
    @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [63:0]  beats[4];
    logic [255:0] d, l_keep;
    exp_t         e;
    int           pat[6] = '{1, 0, 0, 1, 1, 1};
    int           idx[6] = '{0, 1, 1, 1, 2, 3};

    rst_n         = 1'b0;
    bus.line_i    = '0;
    bus.address_i = '0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_read_o",    bus.read_o,    0);
    check("rst_write_o",   bus.write_o,   0);
    check("rst_resp_o",    bus.resp_o,    0);
    check("rst_line_o",    bus.line_o,    0);
    check("rst_address_o", bus.address_o, 0);
    check("rst_burst_o",   bus.burst_o,   0);
`ifdef CACHELINE_ADAPTOR_ERR_EN
    check("rst_err_o",     bus.err_o,     0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-wait read, exact cycle timing
    beats[0] = 64'h1111_1111_1111_1111;
    beats[1] = 64'h2222_2222_2222_2222;
    beats[2] = 64'h3333_3333_3333_3333;
    beats[3] = 64'h4444_4444_4444_4444;
    e.is_read = 1'b1;
    e.addr    = 32'h0000_1220;
    e.line    = {beats[3], beats[2], beats[1], beats[0]};
    sb.push_back(e);
    bus.address_i = 32'h0000_1234;
    bus.read_i    = 1'b1;
    @(negedge clk);
    bus.read_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("zr_read_o_high", bus.read_o, 1);
      check("zr_resp_o_low",  bus.resp_o, 0);
      bus.resp_i  = 1'b1;
      bus.burst_i = beats[k];
      @(negedge clk);
    end
    bus.resp_i = 1'b0;
    check("zr_resp_o_c5",  bus.resp_o,    1);
    check("zr_read_o_c5",  bus.read_o,    0);
    check("zr_line_o",     bus.line_o,    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    check("zr_address_o",  bus.address_o, 32'h0000_1220);
    @(negedge clk);
    check("zr_resp_pulse", bus.resp_o,    0);

    // Write with two wait cycles before beat 1
    d = rand_line();
    e.is_read = 1'b0;
    e.addr    = 32'h0000_8040;
    e.line    = d;
    sb.push_back(e);
    bus.address_i = 32'h0000_805C;
    bus.line_i    = d;
    bus.write_i   = 1'b1;
    @(negedge clk);
    bus.write_i = 1'b0;
    bus.line_i  = rand_line();
    for (int k = 0; k < 6; k++) begin
      check("ww_write_o_high", bus.write_o, 1);
      check("ww_burst_o",      bus.burst_o, d[64*idx[k] +: 64]);
      bus.resp_i = pat[k][0];
      @(negedge clk);
    end
    bus.resp_i = 1'b0;
    check("ww_resp_o_c7",  bus.resp_o,  1);
    check("ww_write_o_c7", bus.write_o, 0);
    @(negedge clk);

    // Back-to-back reads, second held through DONE
    auto_mem  = 1'b1;
    zero_wait = 1'b1;
    do_txn(1'b0, 32'h0000_0100, rand_line());
    do_txn(1'b0, 32'h0000_0200, rand_line());
    e.is_read = 1'b1;
    e.addr    = 32'h0000_0100;
    e.line    = ref_rd(32'h0000_0100);
    sb.push_back(e);
    bus.address_i = 32'h0000_0100;
    bus.read_i    = 1'b1;
    @(negedge clk);
    wait_resp("b2b_first");
    bus.address_i = 32'h0000_0200;
    e.addr = 32'h0000_0200;
    e.line = ref_rd(32'h0000_0200);
    sb.push_back(e);
    @(negedge clk);
    check("b2b_not_early",  bus.read_o,    0);
    @(negedge clk);
    check("b2b_read_o_+2",  bus.read_o,    1);
    check("b2b_address_o",  bus.address_o, 32'h0000_0200);
    bus.read_i = 1'b0;
    wait_resp("b2b_second");
    @(negedge clk);

    // Simultaneous read and write: read first, then the held write
    zero_wait = 1'b0;
    d = rand_line();
    e.is_read = 1'b1;
    e.addr    = 32'h0000_0300;
    e.line    = ref_rd(32'h0000_0300);
    sb.push_back(e);
    e.is_read = 1'b0;
    e.line    = d;
    sb.push_back(e);
    ref_mem[32'h0000_0300] = d;
    bus.address_i = 32'h0000_0300;
    bus.line_i    = d;
    bus.read_i    = 1'b1;
    bus.write_i   = 1'b1;
    @(negedge clk);
    check("sim_read_first",  bus.read_o,  1);
    check("sim_no_write",    bus.write_o, 0);
    wait_resp("sim_read");
    bus.read_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("sim_write_after", bus.write_o, 1);
    bus.write_i = 1'b0;
    wait_resp("sim_write");
    @(negedge clk);
`ifdef CACHELINE_ADAPTOR_ERR_EN
    check("sim_err_o", bus.err_o, 1);
`endif
    do_txn(1'b1, 32'h0000_0300, '0);

    // Reset after beat 1 of a read
    auto_mem      = 1'b0;
    bus.address_i = 32'h0000_0400;
    bus.read_i    = 1'b1;
    @(negedge clk);
    bus.read_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.resp_i  = 1'b1;
      bus.burst_i = {$urandom(), $urandom()};
      @(negedge clk);
    end
    bus.resp_i = 1'b0;
    check("mr_read_o_before", bus.read_o, 1);
    rst_n = 1'b0;
    #1;
    check("mr_read_o_async",  bus.read_o, 0);
    check("mr_resp_o",        bus.resp_o, 0);
    check("mr_line_o",        bus.line_o, 0);
`ifdef CACHELINE_ADAPTOR_ERR_EN
    check("mr_err_o_cleared", bus.err_o,  0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mr_idle_after", bus.read_o, 0);
    auto_mem = 1'b1;
    l_keep = ref_rd(32'h0000_0100);
    do_txn(1'b1, 32'h0000_0100, '0);

    // Stray resp_i while IDLE
    auto_mem = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.resp_i  = 1'b1;
      bus.burst_i = {$urandom(), $urandom()};
      @(negedge clk);
      check("st_read_o", bus.read_o, 0);
      check("st_resp_o", bus.resp_o, 0);
      check("st_line_o", bus.line_o, l_keep);
    end
    bus.resp_i = 1'b0;
`ifdef CACHELINE_ADAPTOR_ERR_EN
    check("st_err_set",    bus.err_o, 1);
    repeat (2) @(negedge clk);
    check("st_err_sticky", bus.err_o, 1);
`endif
    auto_mem = 1'b1;

    // Randomized traffic over a small set of lines so reads hit written data
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      a = 32'h0000_1000 | {24'd0, 3'($urandom_range(0, 7)), 5'd0} | 32'($urandom_range(0, 31));
      do_txn(1'($urandom_range(0, 1)), a, rand_line());
    end

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Bridges the 256-bit cache-line interface (`rv32i_line`) used by the L1 caches to the 64-bit burst physical-memory interface. It converts one line read into a four-beat read burst and one line write into a four-beat write burst, then returns a single-cycle response to the cache. It sits between the cache/arbiter and physical memory, and is the memory-side end of the line protocol the caches initiate.

## Interface
- `BURST_W`, default 64: memory beat width in bits.
- `BURST_LEN`, default 4: beats per line. `BURST_LEN*BURST_W` must equal 256.
- `clk`, in, 1: single clock, rising-edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `line_i`, in, 256: write line from the cache.
- `line_o`, out, 256: assembled read line.
- `address_i`, in, 32: line address from the cache.
- `read_i`, in, 1: cache line-read request, level.
- `write_i`, in, 1: cache line-write request, level.
- `resp_o`, out, 1: transaction complete, one-cycle pulse.
- `burst_i`, in, 64: read beat from memory.
- `burst_o`, out, 64: write beat to memory.
- `address_o`, out, 32: burst address, line-aligned.
- `read_o`, out, 1: memory read burst active.
- `write_o`, out, 1: memory write burst active.
- `resp_i`, in, 1: memory beat accept/valid.
- `err_o`, out, 1: present only under `CACHELINE_ADAPTOR_ERR_EN`; sticky protocol error.

## Operation
- **States:** IDLE, RD_BURST, WR_BURST, DONE. Beat counter is 2 bits (0..3).
- **Reset values:** state IDLE, counter 0, `line_o`=0, `burst_o`=0, `address_o`=0, `read_o`=0, `write_o`=0, `resp_o`=0, `err_o`=0.
- **Request capture (IDLE):**
  - `read_i` sampled high: latch `{address_i[31:5],5'b0}` into `address_o`, go to RD_BURST.
  - Otherwise, `write_i` sampled high: latch the address the same way and latch `line_i` into the internal write buffer, go to WR_BURST.
  - If `read_i` and `write_i` are both high, read wins. The write is not lost; the cache still holds it.
- **RD_BURST:**
  - `read_o`=1.
  - Each cycle with `resp_i`=1, `burst_i` is stored in `line_o[64*cnt +: 64]` and `cnt` increments.
  - On beat 3: `cnt` wraps to 0 and the state goes to DONE.
- **WR_BURST:**
  - `write_o`=1, `burst_o`=buffer[64*cnt +: 64].
  - Each `resp_i`=1 advances `cnt`.
  - On beat 3: go to DONE.
- **DONE:** `resp_o`=1 for exactly one cycle, `read_o`/`write_o`=0, then IDLE.
  - After a read, `line_o` is valid in DONE and holds until the next read beat overwrites it.
- **Request ordering:** `read_i`/`write_i` are ignored outside IDLE. The cache must drop its request in the cycle following `resp_o`, so it is low when IDLE resamples.
- **Memory stalls:** `resp_i`=0 holds the beat index and all outputs stable for any number of cycles.
- **Stray beats:** `resp_i` in IDLE or DONE is ignored for data.
- **Reset mid-burst:** `rst_n` low immediately aborts the burst. `read_o`/`write_o` drop asynchronously, the partial line is discarded, and no `resp_o` is issued.

## Timing
- `read_o`/`write_o`/`address_o` are registered. They rise in the cycle after the request is sampled and stay stable for the whole burst.
- Minimum latency with zero-wait memory:
  - Request high in cycle 0.
  - Burst beats in cycles 1–4.
  - `resp_o` in cycle 5.
  - IDLE in cycle 6.
  - Next request is sampled at the end of cycle 6 at the earliest.
- Each wait cycle (`resp_i`=0 inside a burst) adds exactly one cycle.
- Beat order is fixed, lowest bits first: beat 0 = `[63:0]`, beat 3 = `[255:192]`.

## Configuration
- **`CACHELINE_ADAPTOR_ERR_EN` defined:**
  - `err_o` exists.
  - It sets when `resp_i`=1 in IDLE or DONE.
  - It also sets when `read_i` and `write_i` are sampled high together in IDLE.
  - It stays set until `rst_n` is asserted.
  - It has no effect on data flow.
- **Not defined:** `err_o` port and logic are absent; all other behaviour is identical.

## Test plan
- **Zero-wait read:** `address_i`=0x0000_1234, beats 0x11..,0x22..,0x33..,0x44.. -> `address_o`=0x0000_1220, `read_o` in cycles 1–4, `resp_o` in cycle 5, `line_o`={0x44..,0x33..,0x22..,0x11..}.
- **Write with waits:** `line_i`={D3,D2,D1,D0}, memory inserts 2 wait cycles before beat 1 -> `burst_o` shows D0,D1(held 3 cycles),D2,D3, `write_o` high 6 cycles, `resp_o` in cycle 7.
- **Simultaneous request:** `read_i`=`write_i`=1 -> read burst first, then the write burst after `resp_o` (cache still holding `write_i`). Under `CACHELINE_ADAPTOR_ERR_EN`, `err_o`=1.
- **Reset mid-burst:** `rst_n` low after beat 1 of a read -> `read_o`=0 asynchronously, no `resp_o`, `line_o`=0. A fresh read completes normally afterwards.
- **Stray `resp_i` in IDLE:** -> no state change, no `resp_o`, `line_o` unchanged. Under `CACHELINE_ADAPTOR_ERR_EN`, `err_o` is set and stays set.
- **Back-to-back reads:** second request held through the DONE cycle -> not sampled until IDLE; second `read_o` rises exactly 2 cycles after the first `resp_o`.
